instr_fetch: RTL



---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch_branch_lut.sv | 15 +
 rtl/instr_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the ERICK fetch stage: state enum, HALT encoding
// and the branch-target table read by branch_lut.
package definitions;

  localparam int PC_W_DEF      = 10;
  localparam int INSTR_W_DEF   = 9;
  localparam int LUT_IDX_W_DEF = 5;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

  localparam logic [INSTR_W_DEF-1:0] HALT_INSTR = '1;

  // Target table for the current program; entry i holds 13*i+1.
  localparam logic [PC_W_DEF-1:0] BRANCH_LUT [2**LUT_IDX_W_DEF] = '{
    10'd1,   10'd14,  10'd27,  10'd40,  10'd53,  10'd66,  10'd79,  10'd92,
    10'd105, 10'd118, 10'd131, 10'd144, 10'd157, 10'd170, 10'd183, 10'd196,
    10'd209, 10'd222, 10'd235, 10'd248, 10'd261, 10'd274, 10'd287, 10'd300,
    10'd313, 10'd326, 10'd339, 10'd352, 10'd365, 10'd378, 10'd391, 10'd404
  };

endpackage

// File: rtl/instr_fetch_branch_lut.sv
// Combinational branch-target lookup; swapping the package table retargets
// a program without touching the fetch sequencer.
module branch_lut
  import definitions::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  assign target = PC_W'(BRANCH_LUT[idx]);

endmodule

// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer for the ERICK core.
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module instr_fetch
  import definitions::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic [INSTR_W-1:0] Instr_i,
  input  logic               Branch,
  input  logic               Taken,
  input  logic               Stall,
  output logic [PC_W-1:0]    PC_o,
  output logic [3:0]         Opcode_o,
  output logic               Running,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic               Done,
  output logic [15:0]        CycleCount
`else
  output logic               Done
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] branch_target;
  logic            is_halt;

  assign Opcode_o = Instr_i[INSTR_W-1 -: 4];
  assign is_halt  = (Instr_i == HALT_INSTR[INSTR_W-1:0]);

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .idx    (Instr_i[LUT_IDX_W-1:0]),
    .target (branch_target)
  );

  // HALT outranks Stall, which outranks a taken branch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= FS_IDLE;
      PC_o       <= '0;
      Running    <= 1'b0;
      Done       <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
      CycleCount <= '0;
`endif
    end else begin
      case (state)
        FS_IDLE, FS_DONE: begin
          if (Start) begin
            state      <= FS_RUN;
            PC_o       <= StartAddr;
            Running    <= 1'b1;
            Done       <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
            CycleCount <= '0;
`endif
          end
        end
        FS_RUN: begin
`ifdef FETCH_CYCLE_COUNT_EN
          if (CycleCount != 16'hFFFF)
            CycleCount <= CycleCount + 16'd1;
`endif
          if (is_halt) begin
            state   <= FS_DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (Stall) begin
            PC_o <= PC_o;
          end else if (Branch && Taken) begin
            PC_o <= branch_target;
          end else begin
            PC_o <= PC_o + PC_W'(1);
          end
        end
        default: begin
          state   <= FS_IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
